// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU. Holds one decoded instruction, forwards
// from EX/MEM and MEM/WB, and presents operands under a valid/ready handshake.
module alu_issue_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op_sel,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_wr,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_wr,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2,
  output logic [3:0]        op_sel,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write,
  output logic              illegal_op
);

  logic              valid_q,     valid_d;
  logic              rdy_en_q;
  logic [3:0]        op_q,        op_d;
  logic [REG_AW-1:0] rs1_addr_q,  rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q,  rs2_addr_d;
  logic [XLEN-1:0]   rs1_val_q,   rs1_val_d;
  logic [XLEN-1:0]   rs2_val_q,   rs2_val_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic              use_imm_q,   use_imm_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              reg_write_q, reg_write_d;
  logic              illegal_q,   illegal_d;
  logic              capture;

  // Bypass mux: x0 reads zero, EX/MEM beats MEM/WB, else the supplied value.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a,
                                          input logic [XLEN-1:0]   d);
    if (a == '0)                       return '0;
    else if (exmem_wr && exmem_rd == a) return exmem_result;
    else if (memwb_wr && memwb_rd == a) return memwb_result;
    else                               return d;
  endfunction

  // ALU decodes only these op codes; anything else yields a zero result.
  function automatic logic op_is_illegal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: return 1'b0;
      default:                             return 1'b1;
    endcase
  endfunction

  // Upstream ready: gated off until the cycle after reset releases.
  assign in_ready = rdy_en_q & (~valid_q | out_ready);
  assign capture  = in_valid & in_ready & ~flush;

  // Next-state: capture, retire, flush and stall-time operand refresh.
  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;

    if (valid_q && !capture) begin
      rs1_val_d = fwd(rs1_addr_q, rs1_val_q);
      rs2_val_d = fwd(rs2_addr_q, rs2_val_q);
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      op_d        = in_op_sel;
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
      rs1_val_d   = fwd(in_rs1_addr, in_rs1_data);
      rs2_val_d   = fwd(in_rs2_addr, in_rs2_data);
      imm_d       = in_imm;
      use_imm_d   = in_use_imm;
      rd_d        = in_rd_addr;
      reg_write_d = in_reg_write;
      illegal_d   = op_is_illegal(in_op_sel);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rdy_en_q    <= 1'b0;
      op_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rdy_en_q    <= 1'b1;
      op_q        <= op_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  // Operand outputs see same-cycle producers on top of the stored values.
  assign out_valid     = valid_q;
  assign src1          = fwd(rs1_addr_q, rs1_val_q);
  assign src2          = use_imm_q ? imm_q : fwd(rs2_addr_q, rs2_val_q);
  assign op_sel        = op_q;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = reg_write_q & valid_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, pass-through, forwarding,
// stall refresh, x0/immediate handling, flush and illegal op detection.
module tb_alu_issue_stage;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic [3:0]        in_op_sel;
  logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [XLEN-1:0]   in_rs1_data, in_rs2_data, in_imm;
  logic              in_use_imm, in_reg_write;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic              exmem_wr, memwb_wr;
  logic [XLEN-1:0]   exmem_result, memwb_result;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   src1, src2;
  logic [3:0]        op_sel;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_reg_write, illegal_op;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_sel(in_op_sel),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .exmem_rd(exmem_rd), .exmem_wr(exmem_wr), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_wr(memwb_wr), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1(src1), .src2(src2), .op_sel(op_sel),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a decode offer (in_valid is left asserted).
  task automatic offer(input logic [3:0] op, input logic [4:0] rs1, input logic [63:0] d1,
                       input logic [4:0] rs2, input logic [63:0] d2,
                       input logic ui, input logic [63:0] imm, input logic [4:0] rd);
    in_valid     = 1'b1;
    in_op_sel    = op;
    in_rs1_addr  = rs1;
    in_rs1_data  = d1;
    in_rs2_addr  = rs2;
    in_rs2_data  = d2;
    in_use_imm   = ui;
    in_imm       = imm;
    in_rd_addr   = rd;
    in_reg_write = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_op_sel = 4'd0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0;
    in_reg_write = 1'b0; exmem_rd = '0; memwb_rd = '0; exmem_wr = 1'b0;
    memwb_wr = 1'b0; exmem_result = '0; memwb_result = '0;

    // Reset held three cycles with decode offering
    step(); step(); step();
    chk("rst_valid",   64'(out_valid), 64'(0));
    chk("rst_src1",    src1,           64'(0));
    chk("rst_src2",    src2,           64'(0));
    chk("rst_inready", 64'(in_ready),  64'(0));
    chk("rst_regwr",   64'(out_reg_write), 64'(0));
    reset = 1'b0; in_valid = 1'b0;
    #1 chk("rel_inready0", 64'(in_ready), 64'(0));
    step();
    chk("rel_inready1", 64'(in_ready),  64'(1));
    chk("rel_valid",    64'(out_valid), 64'(0));

    // Plain pass-through
    out_ready = 1'b1;
    offer(4'd2, 5'd3, 64'd10, 5'd4, 64'd5, 1'b0, 64'd0, 5'd1);
    step(); in_valid = 1'b0;
    chk("pass_valid", 64'(out_valid),     64'(1));
    chk("pass_src1",  src1,               64'd10);
    chk("pass_src2",  src2,               64'd5);
    chk("pass_op",    64'(op_sel),        64'd2);
    chk("pass_rd",    64'(out_rd_addr),   64'd1);
    chk("pass_regwr", 64'(out_reg_write), 64'(1));
    chk("pass_ill",   64'(illegal_op),    64'(0));
    step();
    chk("pass_retire", 64'(out_valid),     64'(0));
    chk("pass_regwr0", 64'(out_reg_write), 64'(0));

    // Forwarding priority while held
    out_ready = 1'b0;
    offer(4'd0, 5'd7, 64'h11, 5'd0, 64'd0, 1'b0, 64'd0, 5'd2);
    step(); in_valid = 1'b0;
    exmem_rd = 5'd7; exmem_wr = 1'b1; exmem_result = 64'hAA;
    memwb_rd = 5'd7; memwb_wr = 1'b1; memwb_result = 64'hBB;
    #1 chk("fwd_exmem", src1, 64'hAA);
    exmem_wr = 1'b0;
    #1 chk("fwd_memwb", src1, 64'hBB);
    memwb_wr = 1'b0;
    #1 chk("fwd_none",  src1, 64'h11);
    out_ready = 1'b1;
    step();
    chk("fwd_retire", 64'(out_valid), 64'(0));

    // Producer retires during a stall; refreshed value must survive
    out_ready = 1'b0;
    offer(4'd1, 5'd9, 64'd1, 5'd0, 64'd0, 1'b0, 64'd0, 5'd3);
    step(); in_valid = 1'b0;
    chk("stall_stale",   src1, 64'd1);
    chk("stall_inready", 64'(in_ready), 64'(0));
    exmem_rd = 5'd9; exmem_wr = 1'b1; exmem_result = 64'd42;
    #1 chk("stall_fwd", src1, 64'd42);
    step(); exmem_wr = 1'b0;
    #1 chk("stall_keep1", src1, 64'd42);
    chk("stall_valid", 64'(out_valid), 64'(1));
    step();
    chk("stall_keep2", src1, 64'd42);
    out_ready = 1'b1;
    step();
    chk("stall_retire", 64'(out_valid), 64'(0));

    // x0 is never forwarded; immediate replaces rs2
    exmem_rd = 5'd0; exmem_wr = 1'b1; exmem_result = 64'd99;
    offer(4'd6, 5'd0, 64'd77, 5'd5, 64'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 5'd4);
    out_ready = 1'b0;
    step(); in_valid = 1'b0;
    chk("x0_src1", src1, 64'd0);
    chk("imm_src2", src2, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("x0_refresh", src1, 64'd0);
    exmem_wr = 1'b0; out_ready = 1'b1;
    step();

    // Flush kills held instruction and drops the simultaneous offer
    out_ready = 1'b0;
    offer(4'd1, 5'd2, 64'd3, 5'd0, 64'd0, 1'b0, 64'd0, 5'd5);
    step();
    chk("fl_pre_valid", 64'(out_valid), 64'(1));
    flush = 1'b1;
    offer(4'd7, 5'd6, 64'd33, 5'd0, 64'd0, 1'b0, 64'd0, 5'd6);
    step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid",   64'(out_valid), 64'(0));
    chk("fl_inready", 64'(in_ready),  64'(1));
    chk("fl_op_kept", 64'(op_sel),    64'd1);

    // Illegal op captured, then back-to-back legal op
    out_ready = 1'b1;
    offer(4'd5, 5'd1, 64'd4, 5'd0, 64'd0, 1'b0, 64'd0, 5'd7);
    step();
    chk("ill_flag", 64'(illegal_op), 64'(1));
    chk("ill_op",   64'(op_sel),     64'd5);
    offer(4'd12, 5'd1, 64'd4, 5'd0, 64'd0, 1'b0, 64'd0, 5'd8);
    step(); in_valid = 1'b0;
    chk("b2b_valid", 64'(out_valid),   64'(1));
    chk("b2b_ill",   64'(illegal_op),  64'(0));
    chk("b2b_op",    64'(op_sel),      64'd12);
    chk("b2b_rd",    64'(out_rd_addr), 64'd8);
    step();
    chk("end_valid", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
